// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_pkg : shared types and constants for the div_seq_32 sequencer    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package div_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_BUSY  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [1:0]  OP_DIV  = 2'b00;
  localparam logic [1:0]  OP_DIVU = 2'b01;
  localparam logic [1:0]  OP_REM  = 2'b10;
  localparam logic [1:0]  OP_REMU = 2'b11;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam int          DIV_LAT = 34;

  // Magnitude of a signed operand; unsigned operands pass through.
  function automatic logic [31:0] abs_if(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_seq_32_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_seq_32_if : request/response handshake bundle for div_seq_32     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
interface div_seq_32_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_op_i;
  logic [XLEN-1:0]  req_a_i;
  logic [XLEN-1:0]  req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             flush_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [XLEN-1:0]  resp_data_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic             busy_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, flush_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_tag_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, flush_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_tag_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/int_div_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int_div_32 : unsigned radix-2 restoring divider, one bit per cycle   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module int_div_32 (
  input  logic        clk_i,
  input  logic        load_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] div_q;
  logic [5:0]  cnt_q;
  logic [32:0] shift;
  logic [32:0] diff;

  // Partial remainder stays below the divisor, so bit 32 of diff is a clean borrow flag.
  assign shift = {rem_q, quo_q[31]};
  assign diff  = shift - {1'b0, div_q};

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      quo_q <= a_i;
      rem_q <= '0;
      div_q <= b_i;
      cnt_q <= 6'd32;
    end else if (cnt_q != 6'd0) begin
      cnt_q <= cnt_q - 6'd1;
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shift[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/div_seq_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_seq_32 : RV32M DIV/DIVU/REM/REMU sequencer with result cache     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module div_seq_32 #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int DIV_LAT = div_pkg::DIV_LAT
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  div_seq_32_if.slave  bus
);
  import div_pkg::*;

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]    ua_q, ua_d, ub_q, ub_d;
  logic               qs_q, qs_d, rs_q, rs_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic               cv_q, cv_d, cuns_q, cuns_d;
  logic [XLEN-1:0]    ca_q, ca_d, cb_q, cb_d;
  logic [XLEN-1:0]    cquo_q, cquo_d, crem_q, crem_d;

  logic               div_load;
  logic [XLEN-1:0]    div_quo, div_rem;
  logic               acc, signed_req, hit;
  logic [XLEN-1:0]    qfix, rfix;

  int_div_32 u_div (
    .clk_i  (clk_i),
    .load_i (div_load),
    .a_i    (ua_q),
    .b_i    (ub_q),
    .quo_o  (div_quo),
    .rem_o  (div_rem)
  );

  assign div_load   = (state_q == ST_LOAD);
  assign acc        = bus.req_valid_i && bus.req_ready_o;
  assign signed_req = ~bus.req_op_i[0];
  assign hit        = cv_q && (ca_q == bus.req_a_i) && (cb_q == bus.req_b_i)
                      && (cuns_q == bus.req_op_i[0]);
  assign qfix       = (!op_q[0] && qs_q) ? (~div_quo + 32'd1) : div_quo;
  assign rfix       = (!op_q[0] && rs_q) ? (~div_rem + 32'd1) : div_rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    a_d     = a_q;
    b_d     = b_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    res_d   = res_q;
    cv_d    = cv_q;
    cuns_d  = cuns_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    cquo_d  = cquo_q;
    crem_d  = crem_q;

    unique case (state_q)
      ST_DRAIN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_IDLE: begin
        if (acc) begin
          tag_d = bus.req_tag_i;
          op_d  = bus.req_op_i;
          if (bus.req_b_i == '0) begin
            res_d   = bus.req_op_i[1] ? bus.req_a_i : '1;
            state_d = ST_RESP;
          end else if (signed_req && bus.req_a_i == INT_MIN && bus.req_b_i == '1) begin
            res_d   = bus.req_op_i[1] ? '0 : INT_MIN;
            state_d = ST_RESP;
          end else if (hit) begin
            res_d   = bus.req_op_i[1] ? crem_q : cquo_q;
            state_d = ST_RESP;
          end else begin
            a_d     = bus.req_a_i;
            b_d     = bus.req_b_i;
            ua_d    = abs_if(bus.req_a_i, signed_req);
            ub_d    = abs_if(bus.req_b_i, signed_req);
            qs_d    = bus.req_a_i[31] ^ bus.req_b_i[31];
            rs_d    = bus.req_a_i[31];
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (bus.flush_i) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DIV_LAT);
        end else begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(DIV_LAT - 1);
        end
      end

      ST_BUSY: begin
        if (bus.flush_i) begin
          // The divider keeps running; drain exactly what is left of this run.
          state_d = ST_DRAIN;
        end else if (cnt_q == '0) begin
          res_d   = op_q[1] ? rfix : qfix;
          cv_d    = 1'b1;
          cuns_d  = op_q[0];
          ca_d    = a_q;
          cb_d    = b_q;
          cquo_d  = qfix;
          crem_d  = rfix;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (bus.flush_i || bus.resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_DRAIN;
        cnt_d   = CNT_W'(DIV_LAT);
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_DRAIN;
      cnt_q   <= CNT_W'(DIV_LAT);
      op_q    <= '0;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ua_q    <= '0;
      ub_q    <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      res_q   <= '0;
      cv_q    <= 1'b0;
      cuns_q  <= 1'b0;
      ca_q    <= '0;
      cb_q    <= '0;
      cquo_q  <= '0;
      crem_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      res_q   <= res_d;
      cv_q    <= cv_d;
      cuns_q  <= cuns_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      cquo_q  <= cquo_d;
      crem_q  <= crem_d;
    end
  end

  assign bus.req_ready_o  = (state_q == ST_IDLE) && !bus.flush_i;
  assign bus.resp_valid_o = (state_q == ST_RESP);
  assign bus.resp_data_o  = res_q;
  assign bus.resp_tag_o   = tag_q;
  assign bus.busy_o       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_seq_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_seq_32 : vector table + scoreboard bench for div_seq_32       |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_div_seq_32;
  import div_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          lat;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_seq_32_if #(.XLEN(32), .TAG_W(5)) bus ();

  div_seq_32 #(.XLEN(32), .TAG_W(5), .DIV_LAT(DIV_LAT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  sb_t sb[$];
  int  passed = 0;
  int  total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Present a request once ready is seen, hold it across the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o) begin
      chk("req_ready_timeout", {31'd0, bus.req_ready_o}, 32'd1);
      return;
    end
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_tag_i   = tag;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int hold);
    sb_t e;
    int  lat = 1;
    @(negedge clk);
    while (!bus.resp_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({name, "_valid"}, {31'd0, bus.resp_valid_o}, 32'd1);
    if (!bus.resp_valid_o) return;
    chk({name, "_lat"}, 32'(lat), 32'(e.lat));
    chk({name, "_data"}, bus.resp_data_o, e.data);
    chk({name, "_tag"}, {27'd0, bus.resp_tag_o}, {27'd0, e.tag});
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({name, "_held_valid"}, {31'd0, bus.resp_valid_o}, 32'd1);
      chk({name, "_held_data"}, bus.resp_data_o, e.data);
      chk({name, "_held_tag"}, {27'd0, bus.resp_tag_o}, {27'd0, e.tag});
    end
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int lat, input int hold);
    sb_t e;
    issue(op, a, b, tag);
    e.data = exp;
    e.tag  = tag;
    e.lat  = lat;
    sb.push_back(e);
    wait_resp(name, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v[15];
    int   n;
    bit   seen;

    v[0]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFD, DIV_LAT + 2, 0};
    v[1]  = '{OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF, 1,           0};
    v[2]  = '{OP_DIVU, 32'd5,         32'd0,         5'd3,  32'hFFFF_FFFF, 1,           0};
    v[3]  = '{OP_REM,  32'd5,         32'd0,         5'd4,  32'd5,         1,           0};
    v[4]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  32'h8000_0000, 1,           0};
    v[5]  = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'd0,         1,           0};
    v[6]  = '{OP_REMU, 32'hFFFF_FFFF, 32'd16,        5'd7,  32'h0000_000F, DIV_LAT + 2, 10};
    v[7]  = '{OP_DIVU, 32'd1000,      32'd33,        5'd8,  32'd30,        DIV_LAT + 2, 0};
    v[8]  = '{OP_REMU, 32'd1000,      32'd33,        5'd9,  32'd10,        1,           0};
    v[9]  = '{OP_REM,  32'd1000,      32'd33,        5'd10, 32'd10,        DIV_LAT + 2, 0};
    v[10] = '{OP_DIV,  32'd100,       32'hFFFF_FFF9, 5'd11, 32'hFFFF_FFF2, DIV_LAT + 2, 0};
    v[11] = '{OP_REM,  32'hFFFF_FF9C, 32'd7,         5'd12, 32'hFFFF_FFFE, DIV_LAT + 2, 0};
    v[12] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         DIV_LAT + 2, 0};
    v[13] = '{OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1,           0};
    v[14] = '{OP_DIV,  32'h8000_0000, 32'd1,         5'd15, 32'h8000_0000, DIV_LAT + 2, 0};

    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = 2'b00;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.req_tag_i    = '0;
    bus.flush_i      = 1'b0;
    bus.resp_ready_i = 1'b0;

    // Reset values and drain length
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    chk("rst_resp_data", bus.resp_data_o, 32'd0);
    chk("rst_resp_tag", {27'd0, bus.resp_tag_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd1);
    rst_n = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!bus.req_ready_o && n < 200) begin
      if (bus.resp_valid_o) seen = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("drain_len", 32'(n), 32'(DIV_LAT));
    chk("drain_no_resp", {31'd0, seen}, 32'd0);
    chk("idle_busy", {31'd0, bus.busy_o}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].tag,
             v[i].exp, v[i].lat, v[i].hold);
    end

    // Flush during the sixth BUSY cycle: drain the rest, no response, no cache write
    issue(OP_DIVU, 32'h0001_2345, 32'd3, 5'd20);
    repeat (7) @(negedge clk);
    chk("pre_flush_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("pre_flush_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    while (!bus.req_ready_o && n < 200) begin
      if (bus.resp_valid_o) seen = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("flush_drain_len", 32'(n), 32'(DIV_LAT - 6));
    chk("flush_no_resp", {31'd0, seen}, 32'd0);
    run_op("post_flush_divu", OP_DIVU, 32'd100, 32'd7, 5'd21, 32'd14, DIV_LAT + 2, 0);
    run_op("flushed_not_cached", OP_DIVU, 32'h0001_2345, 32'd3, 5'd22, 32'h0000_6117,
           DIV_LAT + 2, 0);

    // Flush while a response is pending, then flush blocking acceptance
    issue(OP_DIVU, 32'd5, 32'd0, 5'd23);
    @(negedge clk);
    chk("resp_before_flush", {31'd0, bus.resp_valid_o}, 32'd1);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("resp_dropped", {31'd0, bus.resp_valid_o}, 32'd0);
    chk("idle_after_resp_flush", {31'd0, bus.req_ready_o}, 32'd1);
    bus.flush_i     = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_a_i     = 32'd9;
    bus.req_b_i     = 32'd0;
    #1;
    chk("flush_blocks_ready", {31'd0, bus.req_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_no_accept", {31'd0, bus.busy_o}, 32'd0);

    // Asynchronous reset mid-run clears the cache and re-enters DRAIN
    issue(OP_DIVU, 32'd7, 32'd2, 5'd24);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("areset_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("areset_ready", {31'd0, bus.req_ready_o}, 32'd0);
    chk("areset_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("cache_cleared", OP_DIVU, 32'h0001_2345, 32'd3, 5'd25, 32'h0000_6117,
           DIV_LAT + 2, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_seq_32.md
# div_seq_32

Sequencer for the 32-bit iterative integer divider in the RISC-V M-extension execute stage. It accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and resolves special cases (divide-by-zero, signed overflow, repeat operands) without using the divider. It runs all other operations through one shared unsigned divider instance, applies sign correction, and returns the tagged result over a second valid/ready handshake.

## Interface
- `XLEN`, 32: operand and result width.
- `TAG_W`, 5: width of the destination-register tag carried with each request.
- `DIV_LAT`, 34: cycles from divider load launch to a stable quotient/remainder.
- `clk_i` in 1: clock; all block state is updated on the rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: block can accept a request.
- `req_op_i` in 2: funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_a_i` in XLEN: dividend (rs1).
- `req_b_i` in XLEN: divisor (rs2).
- `req_tag_i` in TAG_W: destination tag.
- `flush_i` in 1: kill any accepted, unreturned operation.
- `resp_valid_o` out 1: result present.
- `resp_ready_i` in 1: consumer accepts the result.
- `resp_data_o` out XLEN: quotient or remainder.
- `resp_tag_o` out TAG_W: tag of the result.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- States:
  - DRAIN: wait out a divider run that may still be in progress.
  - IDLE: accept requests.
  - LOAD: launch the divider.
  - BUSY: wait for the divider result.
  - RESP: hold the result until it is taken.
- Reset value: state=DRAIN, drain counter=DIV_LAT, cache valid=0.
- Output reset values: `req_ready_o`=0, `resp_valid_o`=0, `resp_data_o`=0, `resp_tag_o`=0, `busy_o`=1.
- The divider has no reset, so DRAIN counts DIV_LAT cycles and then goes to IDLE.
- `req_ready_o` = (state==IDLE) && !`flush_i`.
- A request is accepted on a cycle with `req_valid_i` && `req_ready_o`.
- On acceptance, exactly one path is taken, in this priority order:
  1. Divisor == 0 → RESP.
     - Result is all-ones for DIV/DIVU and `req_a_i` for REM/REMU.
  2. Signed op, a == 0x8000_0000 and b == 0xFFFF_FFFF → RESP.
     - Result is 0x8000_0000 for DIV and 0 for REM.
  3. Cache hit → RESP with the cached quotient or remainder.
     - Hit means cache valid, same a and b, and same signedness (op[0]).
  4. Otherwise → LOAD.
     - Latch |a| and |b| (two's-complement negation when the op is signed and the operand's MSB is set).
     - Latch result sign = a[31]^b[31] and remainder sign = a[31].
     - Latch op, tag and the raw operands.
- LOAD: drive `div_load`=1 with unsigned mode for one cycle, load the wait counter with DIV_LAT-1, then go to BUSY.
- BUSY: decrement the counter. At 0, capture the divider outputs and go to RESP.
  - Apply sign fixup: quotient negated if signed and result sign set; remainder negated if signed and remainder sign set.
  - Write quotient, remainder, a, b and signedness to the cache and set cache valid.
- RESP: `resp_valid_o`=1 with data and tag held stable. When `resp_ready_i`=1, go to IDLE.
- `flush_i`:
  - In IDLE or RESP: go to IDLE and drop `resp_valid_o` the next cycle. No response is issued.
  - In LOAD or BUSY: go to DRAIN with the remaining cycle count (DIV_LAT for LOAD). The cache is not written.
  - Flush has priority over `resp_ready_i` and over acceptance.
- The cache holds one entry and survives flushes; it is cleared only by reset.

## Timing
- Special-case or cache-hit request: accepted in cycle N, `resp_valid_o` in cycle N+1.
- Divider request: accepted in cycle N, LOAD in N+1, `resp_valid_o` in N+2+DIV_LAT.
- Back-to-back: the next request is accepted no earlier than the cycle after the response handshake. There is no overlap.
- Outputs are registered; there is no combinational path from `resp_ready_i` to `resp_valid_o`.
- An asynchronous reset mid-operation discards everything and enters DRAIN.

## Structure
- Package `div_pkg`:
  - State enum.
  - Op encodings DIV/DIVU/REM/REMU.
  - Constants INT_MIN=0x8000_0000 and DIV_LAT.
- Sub-module: the shared `int_div_32` divider, instantiated here and always run unsigned; sign handling lives in this block.

## Test plan
- After reset, `req_ready_o` stays 0 for DIV_LAT cycles and then rises. `resp_valid_o` stays 0 throughout.
- DIV a=-7, b=2: response −3 (0xFFFF_FFFD) exactly 2+DIV_LAT cycles after acceptance. A following REM with the same operands returns −1 one cycle after acceptance (cache hit).
- DIVU a=5, b=0 → 0xFFFF_FFFF; REM a=5, b=0 → 5. Both respond one cycle after acceptance.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM of the same → 0. Neither loads the divider.
- REMU a=0xFFFF_FFFF, b=16 with `resp_ready_i` held low for 10 cycles → 0xF with tag and data held stable until the handshake.
- `flush_i` 5 cycles into BUSY → no response, DRAIN for the remaining cycles. The next DIVU 100/7 → 14, and the cache does not contain the flushed operands.
